// File: rtl/alut_lookup_arb_pkg.sv
// Shared types and helpers for the ALUT lookup arbiter.
package alut_lookup_arb_pkg;

  // Controller states: waiting for work, lookup in flight, result pulse
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam int MAC_W  = 48;
  localparam int PORT_W = 2;

  // Width of a counter (or index) that must hold the values 0..max_val-1
  function automatic int cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/alut_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after
// rr_ptr (wrapping) wins. Produces a one-hot grant and its binary index.
module alut_rr_pick
  import alut_lookup_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_low;
  logic [2*NUM_REQ-1:0] grant_dbl;

  // Rotate so rr_ptr sits at bit 0, keep the lowest set bit, rotate back
  always_comb begin
    req_dbl   = {req, req} >> rr_ptr;
    rot_req   = req_dbl[NUM_REQ-1:0];
    rot_low   = rot_req & (~rot_req + 1'b1);
    grant_dbl = {rot_low, rot_low} << rr_ptr;
    grant     = grant_dbl[2*NUM_REQ-1:NUM_REQ];
    grant_any = |req;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) grant_idx = grant_idx | IDX_W'(k);
    end
  end

endmodule

// File: rtl/alut_lookup_arb.sv
// Round-robin lookup controller sharing the single ALUT lookup port between
// NUM_REQ requesters, with a timeout watchdog on the ALUT acknowledge.
// Optional feature: define ALUT_ARB_AGE_EN to inject periodic ageing scans.
module alut_lookup_arb
  import alut_lookup_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 16,
  parameter int AGE_PERIOD = 1024
) (
  input  logic                      pclk,
  input  logic                      p_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*MAC_W-1:0]  req_addr,
  input  logic [NUM_REQ*PORT_W-1:0] req_port,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_hit,
  output logic [PORT_W-1:0]         rsp_dest,
  output logic                      rsp_timeout,
  output logic                      lut_req,
  output logic [MAC_W-1:0]          lut_addr,
  output logic [PORT_W-1:0]         lut_port,
  output logic                      lut_age,
  input  logic                      lut_ack,
  input  logic                      lut_hit,
  input  logic [PORT_W-1:0]         lut_dest,
  output logic                      busy
);

  localparam int IDX_W = cnt_width(NUM_REQ);
  localparam int TO_W  = cnt_width(TIMEOUT);

  arb_state_t         state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   winner_reg;
  logic               age_cmd_reg;
  logic [TO_W-1:0]    to_cnt_reg;

  logic [MAC_W-1:0]   addr_arr [NUM_REQ];
  logic [PORT_W-1:0]  port_arr [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic               age_grant;

  // Split the flat request buses into per-requester fields
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*MAC_W +: MAC_W];
      assign port_arr[gi] = req_port[gi*PORT_W +: PORT_W];
    end
  endgenerate

  alut_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  assign rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;

`ifdef ALUT_ARB_AGE_EN
  localparam int AGE_W = cnt_width(AGE_PERIOD);

  logic [AGE_W-1:0] age_cnt_reg;
  logic             age_pending_reg;
  logic             age_overdue_reg;
  logic             age_wrap;

  assign age_wrap  = (age_cnt_reg == AGE_W'(AGE_PERIOD-1));
  // Idle-time scan normally yields to requesters; once overdue it goes first
  assign age_grant = (state_reg == ST_IDLE) && age_pending_reg &&
                     (age_overdue_reg || (req_valid == '0));

  // Free-running age period counter; a wrap seen while still pending marks overdue
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      age_cnt_reg     <= '0;
      age_pending_reg <= 1'b0;
      age_overdue_reg <= 1'b0;
    end else begin
      age_cnt_reg <= age_wrap ? '0 : age_cnt_reg + 1'b1;
      if (age_wrap) begin
        age_pending_reg <= 1'b1;
        age_overdue_reg <= age_pending_reg && !age_grant;
      end else if (age_grant) begin
        age_pending_reg <= 1'b0;
        age_overdue_reg <= 1'b0;
      end
    end
  end
`else
  logic unused_age_cfg;
  assign unused_age_cfg = ^AGE_PERIOD;
  assign age_grant      = 1'b0;
`endif

  // Controller FSM with all outputs registered
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= '0;
      winner_reg  <= '0;
      age_cmd_reg <= 1'b0;
      to_cnt_reg  <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_hit     <= 1'b0;
      rsp_dest    <= '0;
      rsp_timeout <= 1'b0;
      lut_req     <= 1'b0;
      lut_addr    <= '0;
      lut_port    <= '0;
      lut_age     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state_reg)
        ST_IDLE: begin
          to_cnt_reg <= '0;
          if (age_grant) begin
            state_reg   <= ST_LOOKUP;
            age_cmd_reg <= 1'b1;
            lut_req     <= 1'b1;
            lut_age     <= 1'b1;
            lut_addr    <= '0;
            lut_port    <= '0;
            busy        <= 1'b1;
          end else if (pick_any) begin
            state_reg   <= ST_LOOKUP;
            age_cmd_reg <= 1'b0;
            winner_reg  <= pick_idx;
            rr_ptr_reg  <= rr_ptr_next;
            req_ready   <= pick_grant;
            lut_req     <= 1'b1;
            lut_age     <= 1'b0;
            lut_addr    <= addr_arr[pick_idx];
            lut_port    <= port_arr[pick_idx];
            busy        <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          if (lut_ack) begin
            state_reg   <= ST_RESP;
            lut_req     <= 1'b0;
            lut_age     <= 1'b0;
            rsp_valid   <= age_cmd_reg ? '0 : (NUM_REQ'(1) << winner_reg);
            rsp_hit     <= lut_hit && !age_cmd_reg;
            rsp_dest    <= age_cmd_reg ? '0 : lut_dest;
            rsp_timeout <= 1'b0;
          end else if (to_cnt_reg == TO_W'(TIMEOUT-1)) begin
            state_reg   <= ST_RESP;
            lut_req     <= 1'b0;
            lut_age     <= 1'b0;
            rsp_valid   <= age_cmd_reg ? '0 : (NUM_REQ'(1) << winner_reg);
            rsp_hit     <= 1'b0;
            rsp_dest    <= '0;
            rsp_timeout <= !age_cmd_reg;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ST_RESP: begin
          state_reg   <= ST_IDLE;
          rsp_hit     <= 1'b0;
          rsp_dest    <= '0;
          rsp_timeout <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          lut_req   <= 1'b0;
          lut_age   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
